dbuf_deadtime_seq: RTL and testbench
====================================

Name: dbuf_deadtime_seq

Overview:
- Gate-drive sequencer for the step-down converter LOOP/CONTROL path.
- Converts a single PWM request into two non-overlapping enables, hs_o and ls_o, which drive the high-side and low-side dbuf cells.
- Inserts programmable dead time, enforces a minimum high-side on-time, and latches a fault shutdown.
- Sits between the loop PWM comparator logic and the gate buffer cells.

Parameters:
- DT_W, 6, width of the dead-time fields and of the dead-time counter.
- MINON_W, 6, width of the min_on field and of the min-on counter.

Ports:
- CELCLK  in  1  clock; all state changes on its rising edge.
- CELRST  in  1  synchronous reset, active-high.
- CELV  in  1  supply pin, no logic function.
- CELG  in  1  ground pin, no logic function.
- SUB  in  1  substrate pin, no logic function.
- en  in  1  converter enable.
- pwm  in  1  PWM request: 1 = high side on, 0 = low side on.
- dt_lh  in  DT_W  dead time in cycles for the LS-to-HS transition.
- dt_hl  in  DT_W  dead time in cycles for the HS-to-LS transition.
- min_on  in  MINON_W  minimum extra high-side on-cycles.
- fault  in  1  fault request (overcurrent/UVLO); level-sensitive.
- clr_fault  in  1  fault clear request.
- hs_o  out  1  high-side enable.
- ls_o  out  1  low-side enable.
- flt_o  out  1  fault latched.
- state_o  out  3  current state encoding, for debug.

Behaviour:
- States and encodings: IDLE=0, DT_TO_HS=1, HS_ON=2, DT_TO_LS=3, LS_ON=4, FAULT=5. Encodings 6 and 7 are illegal and recover to IDLE on the next edge.
- Outputs are Moore-decoded from a registered state (no combinational path from inputs to outputs):
  - hs_o = (state==HS_ON)
  - ls_o = (state==LS_ON)
  - flt_o = (state==FAULT)
- Reset (CELRST=1 at an edge): state=IDLE, both counters=0, hs_o=0, ls_o=0, flt_o=0, state_o=0. Reset mid-operation follows the same rule; hs_o and ls_o go low on that edge.
- Priority at every edge: CELRST > fault > !en > normal transitions.
  - fault=1 in any state: go to FAULT.
  - en=0 in any non-FAULT state: go to IDLE.
- IDLE: en & pwm goes to DT_TO_HS and loads the dead-time counter with dt_lh. en & !pwm goes to DT_TO_LS and loads it with dt_hl.
- Dead-time counter load value: load max(value,1).
- DT_TO_HS / DT_TO_LS:
  - If the counter is 1, go to the target state (HS_ON / LS_ON); otherwise decrement.
  - The state therefore lasts max(dt,1) cycles with both outputs 0.
  - pwm changes during dead time are ignored; dead time always completes.
- HS_ON:
  - On entry, load the min-on counter with min_on.
  - Each cycle: if pwm=0 and the counter is 0, go to DT_TO_LS (loading dt_hl); otherwise decrement the counter, saturating at 0.
  - Minimum high-side pulse is min_on+1 cycles.
- LS_ON: pwm=1 goes to DT_TO_HS, loading dt_lh. No minimum on-time applies.
- FAULT:
  - hs_o=ls_o=0 and flt_o=1.
  - Exit to IDLE only when clr_fault=1 and fault=0 in the same cycle.
  - clr_fault while fault=1 is ignored.
- Config sampling: dt_lh, dt_hl and min_on are sampled only at counter load. Mid-interval changes take effect at the next load.
- Invariants, required at every cycle:
  - Never hs_o & ls_o.
  - Any HS-to-LS or LS-to-HS change passes through at least 1 cycle with both outputs 0.
  - hs_o/ls_o are never asserted while flt_o=1.
- Latency: with pwm rising while in LS_ON and sampled at edge t, ls_o falls at t, and hs_o rises at t + max(dt_lh,1) edges.

Decomposition:
- Package dbuf_seq_pkg holds:
  - the state enum and encodings;
  - DT_W/MINON_W defaults;
  - the STATE_W=3 constant.
- One sub-module, dbuf_dt_counter: loadable down-counter with a width parameter, load, dec and is_zero/is_one flags, saturating at 0.
  - Instantiated twice: dead-time counter and min-on counter.
- FSM and output decode live in dbuf_deadtime_seq.

Test Plan:
- Reset, then en=1, pwm=0, dt_hl=3: ls_o rises 3 cycles after en is sampled; hs_o stays 0 throughout.
- LS_ON, pwm rises with dt_lh=5, min_on=4, then pwm falls after 1 cycle with dt_hl=2: ls_o falls; hs_o is high after 5 dead cycles for exactly 5 cycles (the min_on floor); then 2 dead cycles; then ls_o rises.
- dt_lh=0: dead time is exactly 1 cycle. Also change dt_lh from 2 to 10 during DT_TO_HS: the current dead time stays 2 cycles.
- fault=1 during HS_ON: next edge gives hs_o=0, flt_o=1. Then clr_fault=1 with fault=1: FAULT is held. Then clr_fault=1 with fault=0: IDLE on the next edge.
- en=0 during DT_TO_HS, and CELRST=1 during LS_ON: both outputs are 0 on the next edge and state_o=0.
- 10k cycles of random pwm/en/fault/config with an assertion checker: never hs_o & ls_o, and every polarity change has at least 1 both-off cycle.

Source files
------------

// File: rtl/dbuf_seq_pkg.sv
// Shared definitions for the dead-time gate-drive sequencer: state
// encodings, default field widths and the debug state width.
package dbuf_seq_pkg;

  localparam int STATE_W     = 3;
  localparam int DT_W_DEF    = 6;
  localparam int MINON_W_DEF = 6;

  // Encodings are visible on state_o, so they are pinned explicitly.
  typedef enum logic [STATE_W-1:0] {
    S_IDLE     = 3'd0,
    S_DT_TO_HS = 3'd1,
    S_HS_ON    = 3'd2,
    S_DT_TO_LS = 3'd3,
    S_LS_ON    = 3'd4,
    S_FAULT    = 3'd5
  } seqState_t;

endpackage

// File: rtl/dbuf_dt_counter.sv
// Loadable down-counter used for both the dead-time interval and the
// high-side minimum on-time. Load wins over decrement; decrement holds at 0.
module dbuf_dt_counter #(
  parameter int W = 6
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_loadVal,
  input  logic         i_dec,
  output logic         o_isZero,
  output logic         o_isOne
);

  logic [W-1:0] r_count;

  // Count register: reload on request, otherwise step down and stick at zero.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_isZero = (r_count == '0);
  assign o_isOne  = (r_count == W'(1));

endmodule

// File: rtl/dbuf_deadtime_seq.sv
// Gate-drive sequencer: turns one PWM request into non-overlapping
// high-side / low-side enables with programmable dead time, a high-side
// minimum on-time and a latched fault shutdown.
module dbuf_deadtime_seq
  import dbuf_seq_pkg::*;
#(
  parameter int DT_W    = DT_W_DEF,
  parameter int MINON_W = MINON_W_DEF
) (
  input  logic               CELCLK,
  input  logic               CELRST,
  input  logic               CELV,
  input  logic               CELG,
  input  logic               SUB,
  input  logic               en,
  input  logic               pwm,
  input  logic [DT_W-1:0]    dt_lh,
  input  logic [DT_W-1:0]    dt_hl,
  input  logic [MINON_W-1:0] min_on,
  input  logic               fault,
  input  logic               clr_fault,
  output logic               hs_o,
  output logic               ls_o,
  output logic               flt_o,
  output logic [STATE_W-1:0] state_o
);

  seqState_t         r_state;
  logic              r_hs;
  logic              r_ls;
  logic              r_flt;

  seqState_t         w_nextState;
  logic              w_dtLoad;
  logic              w_dtDec;
  logic [DT_W-1:0]   w_dtSel;
  logic [DT_W-1:0]   w_dtLoadVal;
  logic              w_dtIsOne;
  logic              w_dtIsZero;
  logic              w_mLoad;
  logic              w_mDec;
  logic              w_mIsZero;
  logic              w_mIsOne;
  logic              w_unusedPins;

  // Power/substrate pins carry no logic; fold them so they are consumed.
  assign w_unusedPins = ^{CELV, CELG, SUB, w_dtIsZero, w_mIsOne};

  // A zero dead-time setting still yields one both-off cycle.
  assign w_dtLoadVal = (w_dtSel == '0) ? DT_W'(1) : w_dtSel;

  dbuf_dt_counter #(.W(DT_W)) u_dtCounter (
    .i_clk     (CELCLK),
    .i_rst     (CELRST),
    .i_load    (w_dtLoad),
    .i_loadVal (w_dtLoadVal),
    .i_dec     (w_dtDec),
    .o_isZero  (w_dtIsZero),
    .o_isOne   (w_dtIsOne)
  );

  dbuf_dt_counter #(.W(MINON_W)) u_minOnCounter (
    .i_clk     (CELCLK),
    .i_rst     (CELRST),
    .i_load    (w_mLoad),
    .i_loadVal (min_on),
    .i_dec     (w_mDec),
    .o_isZero  (w_mIsZero),
    .o_isOne   (w_mIsOne)
  );

  // Next-state and counter control: fault beats disable beats normal flow.
  always_comb begin
    w_nextState = r_state;
    w_dtLoad    = 1'b0;
    w_dtDec     = 1'b0;
    w_dtSel     = dt_lh;
    w_mLoad     = 1'b0;
    w_mDec      = 1'b0;
    if (fault) begin
      w_nextState = S_FAULT;
    end else if (!en && (r_state != S_FAULT)) begin
      w_nextState = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_dtLoad = 1'b1;
          if (pwm) begin
            w_nextState = S_DT_TO_HS;
            w_dtSel     = dt_lh;
          end else begin
            w_nextState = S_DT_TO_LS;
            w_dtSel     = dt_hl;
          end
        end
        S_DT_TO_HS: begin
          if (w_dtIsOne) begin
            w_nextState = S_HS_ON;
            w_mLoad     = 1'b1;
          end else begin
            w_dtDec = 1'b1;
          end
        end
        S_HS_ON: begin
          if (!pwm && w_mIsZero) begin
            w_nextState = S_DT_TO_LS;
            w_dtLoad    = 1'b1;
            w_dtSel     = dt_hl;
          end else begin
            w_mDec = 1'b1;
          end
        end
        S_DT_TO_LS: begin
          if (w_dtIsOne) begin
            w_nextState = S_LS_ON;
          end else begin
            w_dtDec = 1'b1;
          end
        end
        S_LS_ON: begin
          if (pwm) begin
            w_nextState = S_DT_TO_HS;
            w_dtLoad    = 1'b1;
            w_dtSel     = dt_lh;
          end
        end
        S_FAULT: begin
          if (clr_fault) begin
            w_nextState = S_IDLE;
          end
        end
        default: begin
          w_nextState = S_IDLE;
        end
      endcase
    end
  end

  // State register with outputs decoded from the next state so they are registered too.
  always_ff @(posedge CELCLK) begin
    if (CELRST) begin
      r_state <= S_IDLE;
      r_hs    <= 1'b0;
      r_ls    <= 1'b0;
      r_flt   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_hs    <= (w_nextState == S_HS_ON);
      r_ls    <= (w_nextState == S_LS_ON);
      r_flt   <= (w_nextState == S_FAULT);
    end
  end

  assign hs_o    = r_hs;
  assign ls_o    = r_ls;
  assign flt_o   = r_flt;
  assign state_o = r_state;

endmodule

// File: tb/tb_dbuf_deadtime_seq.sv
// Directed and randomized bench for the dead-time gate-drive sequencer.
module tb_dbuf_deadtime_seq;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DTHS = 3'd1;
  localparam logic [2:0] ST_HS   = 3'd2;
  localparam logic [2:0] ST_DTLS = 3'd3;
  localparam logic [2:0] ST_LS   = 3'd4;
  localparam logic [2:0] ST_FLT  = 3'd5;

  logic       CELCLK;
  logic       CELRST;
  logic       CELV;
  logic       CELG;
  logic       SUB;
  logic       en;
  logic       pwm;
  logic [5:0] dtLh;
  logic [5:0] dtHl;
  logic [5:0] minOn;
  logic       fault;
  logic       clrFault;
  logic       hsO;
  logic       lsO;
  logic       fltO;
  logic [2:0] stateO;

  int errors;
  int checks;

  dbuf_deadtime_seq #(.DT_W(6), .MINON_W(6)) dut (
    .CELCLK    (CELCLK),
    .CELRST    (CELRST),
    .CELV      (CELV),
    .CELG      (CELG),
    .SUB       (SUB),
    .en        (en),
    .pwm       (pwm),
    .dt_lh     (dtLh),
    .dt_hl     (dtHl),
    .min_on    (minOn),
    .fault     (fault),
    .clr_fault (clrFault),
    .hs_o      (hsO),
    .ls_o      (lsO),
    .flt_o     (fltO),
    .state_o   (stateO)
  );

  // Free-running 10-unit clock.
  initial begin
    CELCLK = 1'b0;
    forever #5 CELCLK = ~CELCLK;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CELCLK);
    #1;
  endtask

  task automatic applyStimulus(input logic iEn, input logic iPwm,
                               input logic [5:0] iDtLh, input logic [5:0] iDtHl,
                               input logic [5:0] iMinOn, input logic iFault,
                               input logic iClr);
    en       = iEn;
    pwm      = iPwm;
    dtLh     = iDtLh;
    dtHl     = iDtHl;
    minOn    = iMinOn;
    fault    = iFault;
    clrFault = iClr;
  endtask

  // Expected enables follow directly from the expected state.
  task automatic checkOutput(input string tag, input logic [2:0] expState);
    logic [5:0] obs;
    logic [5:0] exp;
    obs = {hsO, lsO, fltO, stateO};
    exp = {(expState == ST_HS), (expState == ST_LS), (expState == ST_FLT), expState};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed hs/ls/flt/state=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkBit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Directed sequence followed by a randomized invariant soak.
  initial begin
    logic prevHs;
    logic prevLs;
    errors = 0;
    checks = 0;
    CELV   = 1'b1;
    CELG   = 1'b0;
    SUB    = 1'b0;
    CELRST = 1'b1;
    applyStimulus(1'b0, 1'b0, 6'd5, 6'd3, 6'd4, 1'b0, 1'b0);
    tick(2);
    checkOutput("reset", ST_IDLE);
    CELRST = 1'b0;
    tick(1);
    checkOutput("idle_en0", ST_IDLE);

    // Start into low side with 3-cycle dead time
    applyStimulus(1'b1, 1'b0, 6'd5, 6'd3, 6'd4, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checkOutput("start_dtls", ST_DTLS);
    end
    tick(1);
    checkOutput("start_ls_on", ST_LS);

    // LS -> HS with dt_lh=5, pwm drops after one cycle, min_on=4 floor
    applyStimulus(1'b1, 1'b1, 6'd5, 6'd2, 6'd4, 1'b0, 1'b0);
    tick(1);
    checkOutput("lh_dt_first", ST_DTHS);
    pwm = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checkOutput("lh_dt", ST_DTHS);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checkOutput("minon_hs", ST_HS);
    end
    for (int i = 0; i < 2; i++) begin
      tick(1);
      checkOutput("hl_dt", ST_DTLS);
    end
    tick(1);
    checkOutput("hl_ls_on", ST_LS);

    // dt_lh=0 gives exactly one dead cycle
    applyStimulus(1'b1, 1'b1, 6'd0, 6'd2, 6'd0, 1'b0, 1'b0);
    tick(1);
    checkOutput("dt0_dead", ST_DTHS);
    tick(1);
    checkOutput("dt0_hs", ST_HS);
    pwm = 1'b0;
    tick(1);
    checkOutput("dt0_back_dtls1", ST_DTLS);
    tick(1);
    checkOutput("dt0_back_dtls2", ST_DTLS);
    tick(1);
    checkOutput("dt0_back_ls", ST_LS);

    // Changing dt_lh mid dead time does not stretch the current interval
    applyStimulus(1'b1, 1'b1, 6'd2, 6'd2, 6'd0, 1'b0, 1'b0);
    tick(1);
    checkOutput("cfg_dt_a", ST_DTHS);
    dtLh = 6'd10;
    tick(1);
    checkOutput("cfg_dt_b", ST_DTHS);
    tick(1);
    checkOutput("cfg_hs", ST_HS);

    // Fault latch and clear handshake
    fault = 1'b1;
    tick(1);
    checkOutput("fault_enter", ST_FLT);
    clrFault = 1'b1;
    tick(1);
    checkOutput("fault_clr_blocked1", ST_FLT);
    tick(1);
    checkOutput("fault_clr_blocked2", ST_FLT);
    fault    = 1'b0;
    clrFault = 1'b0;
    tick(1);
    checkOutput("fault_hold", ST_FLT);
    clrFault = 1'b1;
    tick(1);
    checkOutput("fault_cleared", ST_IDLE);
    clrFault = 1'b0;

    // Disable during dead time, then reset during low-side on
    tick(1);
    checkOutput("dis_dths", ST_DTHS);
    en = 1'b0;
    tick(1);
    checkOutput("dis_idle", ST_IDLE);
    applyStimulus(1'b1, 1'b0, 6'd2, 6'd1, 6'd0, 1'b0, 1'b0);
    tick(1);
    checkOutput("rst_dtls", ST_DTLS);
    tick(1);
    checkOutput("rst_ls", ST_LS);
    CELRST = 1'b1;
    tick(1);
    checkOutput("rst_mid", ST_IDLE);
    CELRST = 1'b0;

    // Random soak checking overlap, fault masking and both-off transitions
    prevHs = hsO;
    prevLs = lsO;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 7) == 0) pwm = ~pwm;
      en       = ($urandom_range(0, 49) != 0);
      fault    = ($urandom_range(0, 99) == 0);
      clrFault = ($urandom_range(0, 3) == 0);
      dtLh     = 6'($urandom_range(0, 7));
      dtHl     = 6'($urandom_range(0, 7));
      minOn    = 6'($urandom_range(0, 7));
      tick(1);
      checkBit("rnd_overlap", hsO & lsO, 1'b0);
      checkBit("rnd_flt_mask", fltO & (hsO | lsO), 1'b0);
      checkBit("rnd_no_deadtime", (prevHs & lsO) | (prevLs & hsO), 1'b0);
      prevHs = hsO;
      prevLs = lsO;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
